// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - round-robin RAM port arbiter with grant lock and burst limit (optional ARB_PRIO0_EN: requester 0 priority)
module ram_arbiter #(
  parameter int NREQ      = 3,
  parameter int BURST_MAX = 4,
  parameter int CW        = 3
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic [NREQ-1:0]      req_ren,
  input  logic [NREQ-1:0]      req_wen,
  input  logic [NREQ*32-1:0]   req_addr,
  input  logic [NREQ*32-1:0]   req_store,
  input  logic [NREQ-1:0]      req_lock,
  output logic [NREQ-1:0]      req_wait,
  output logic [NREQ*32-1:0]   req_load,
  output logic [NREQ-1:0]      gnt,
  output logic                 ramREN,
  output logic                 ramWEN,
  output logic [31:0]          ramaddr,
  output logic [31:0]          ramstore,
  input  logic [31:0]          ramload,
  input  logic [1:0]           ramstate,
  output logic                 err
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // ramstate encoding: FREE=0, BUSY=1, ACCESS=2, ERROR=3
  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t          state_q;
  logic [NREQ-1:0] gnt_q;
  logic [IW-1:0]   gidx_q;
  logic [IW-1:0]   rr_ptr_q;
  logic [CW-1:0]   burst_cnt_q;
  logic            err_q;

  logic [NREQ-1:0] req;
  logic            req_g;
  logic            lock_g;
  logic            other_pend;
  logic            burst_last;
  logic            rr_upd;
  logic            pick_valid;
  logic [IW-1:0]   pick_idx;
  logic [NREQ-1:0] pick_oh;

  assign req = req_ren | req_wen;

`ifdef ARB_PRIO0_EN
  // Requester-0 grants leave the round-robin pointer alone so the others keep their order
  assign rr_upd = (gidx_q != '0);
`else
  assign rr_upd = 1'b1;
`endif

  // Summaries of the granted requester and of everyone else
  always_comb begin
    req_g      = |(req & gnt_q);
    lock_g     = |(req_lock & gnt_q);
    other_pend = |(req & ~gnt_q);
    burst_last = ((int'(burst_cnt_q) + 1) >= BURST_MAX);
  end

  // Round-robin pick: first requester searching upward from rr_ptr+1 with wrap
  always_comb begin
    int            s;
    logic [IW-1:0] cand;
    pick_valid = 1'b0;
    pick_idx   = '0;
    s          = 0;
    cand       = '0;
    for (int k = 1; k <= NREQ; k++) begin
      s = int'(rr_ptr_q) + k;
      if (s >= NREQ) s = s - NREQ;
      cand = IW'(s);
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
`ifdef ARB_PRIO0_EN
    if (req[0]) begin
      pick_valid = 1'b1;
      pick_idx   = '0;
    end
`endif
    for (int i = 0; i < NREQ; i++) begin
      pick_oh[i] = (pick_idx == IW'(i));
    end
  end

  // Forward the granted requester to the RAM port; everyone else waits
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    req_wait = '1;
    req_load = '0;
    if (state_q == GRANT) begin
      for (int i = 0; i < NREQ; i++) begin
        if (gnt_q[i]) begin
          ramWEN                = req_wen[i];
          ramREN                = req_ren[i] & ~req_wen[i];
          ramaddr               = req_addr[i*32 +: 32];
          ramstore              = req_store[i*32 +: 32];
          req_wait[i]           = (ramstate != RS_ACCESS);
          req_load[i*32 +: 32]  = ramload;
        end
      end
    end
  end

  // Arbitration FSM: grant, hold while locked, release on drop or burst limit
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gidx_q      <= '0;
      rr_ptr_q    <= IW'(NREQ - 1);
      burst_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            gnt_q       <= pick_oh;
            gidx_q      <= pick_idx;
            burst_cnt_q <= '0;
            state_q     <= GRANT;
          end
        end
        GRANT: begin
          if (ramstate == RS_ERROR) begin
            err_q <= 1'b1;
          end else if (!req_g && !lock_g) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            if (rr_upd) rr_ptr_q <= gidx_q;
          end else if ((ramstate == RS_ACCESS) && !lock_g && burst_last && other_pend) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            if (rr_upd) rr_ptr_q <= gidx_q;
          end else if ((ramstate == RS_ACCESS) && req_g && (burst_cnt_q < CW'(BURST_MAX))) begin
            burst_cnt_q <= burst_cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
        end
      endcase
    end
  end

  assign gnt = gnt_q;
  assign err = err_q;

endmodule
